seq_stream_ctrl: RTL and testbench

Sequencing controller for the serial "100" sequence-detector datapath. On a start request it clears the detector, shifts a parallel-loaded word into the detector's serial input one bit per clock, and waits a drain window for the detector's registered output. It counts detector hits over the run and signals completion with a one-cycle done pulse. It sits between the board-level control inputs and the detector instance.

---
 rtl/seq_stream_ctrl_if.sv | 27 ++
 rtl/seq_stream_ctrl.sv | 61 ++++++
 tb/tb_seq_stream_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seq_stream_ctrl_if.sv
// seq_stream_ctrl_if: handshake/bus bundle between board control, controller and detector
// Signals:
//   start, data_in, det_hit                   driven by the board/detector side (master)
//   det_clr, ser_bit, ser_valid, busy, done,
//   hit_count                                 driven by the controller (slave)
interface seq_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             det_hit;
  logic             det_clr;
  logic             ser_bit;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  modport master (
    output start, data_in, det_hit,
    input  det_clr, ser_bit, ser_valid, busy, done, hit_count
  );
  modport slave (
    input  start, data_in, det_hit,
    output det_clr, ser_bit, ser_valid, busy, done, hit_count
  );
endinterface

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: clears the "100" detector, streams a captured word MSB first, drains, counts hits
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of seq_stream_ctrl_if:
//        in  start, data_in, det_hit
//        out det_clr, ser_bit, ser_valid, busy, done, hit_count
module seq_stream_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 4
) (
  input logic clk,
  input logic rst,
  seq_stream_ctrl_if.slave bus
);
  localparam int CMAX = WIDTH > DRAIN_CYC ? WIDTH : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] hit_count;
  logic             accept, counting;
  assign accept   = state == IDLE && bus.start;
  assign counting = state == SHIFT || state == DRAIN;
  // One counter serves both the bit count in SHIFT and the drain count in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      hit_count <= '0;
    end else begin
      state     <= state_nx;
      shift_reg <= accept ? bus.data_in : state == SHIFT ? shift_reg << 1 : shift_reg;
      cnt       <= state == CLEAR ? CW'(WIDTH - 1)
                 : state == SHIFT && cnt == '0 ? CW'(DRAIN_CYC - 1)
                 : counting && cnt != '0 ? cnt - 1'b1 : cnt;
      hit_count <= accept ? '0
                 : counting && bus.det_hit && hit_count != '1 ? hit_count + 1'b1 : hit_count;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? CLEAR : IDLE;
      CLEAR:   state_nx = SHIFT;
      SHIFT:   state_nx = cnt == '0 ? DRAIN : SHIFT;
      DRAIN:   state_nx = cnt == '0 ? DONE : DRAIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.det_clr   = state == CLEAR;
  assign bus.ser_valid = state == SHIFT;
  assign bus.ser_bit   = state == SHIFT && shift_reg[WIDTH-1];
  assign bus.busy      = state == CLEAR || counting;
  assign bus.done      = state == DONE;
  assign bus.hit_count = hit_count;
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: randomized self-checking bench for seq_stream_ctrl against a cycle-position model
module tb_seq_stream_ctrl;
  localparam int W = 8;
  localparam int D = 2;
  localparam int RUN = W + D + 3;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  logic [3:0] prev = '0;
  seq_stream_ctrl_if #(.WIDTH(W), .CNT_W(4)) b ();
  seq_stream_ctrl_if #(.WIDTH(W), .CNT_W(2)) b2 ();
  seq_stream_ctrl #(.WIDTH(W), .DRAIN_CYC(D), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  seq_stream_ctrl #(.WIDTH(W), .DRAIN_CYC(D), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  always #5 clk = ~clk;
  logic [8:0] obs;
  assign obs = {b.det_clr, b.ser_bit, b.ser_valid, b.busy, b.done, b.hit_count};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] sat_hits(input logic [15:0] hits, input int upto, input int maxv);
    int n = 0;
    for (int j = 2; j < upto && j <= W + D + 1; j++) n += int'(hits[j]);
    return logic'(0) | 4'(n > maxv ? maxv : n);
  endfunction
  // Drives one run starting at relative cycle 0 and checks every cycle of it.
  task automatic run(input logic [7:0] d, input logic [15:0] hits, input bit spam);
    logic [8:0] exp;
    logic ev;
    for (int c = 0; c < RUN; c++) begin
      b.start   = (c == 0) || spam;
      b.data_in = c == 0 ? d : spam ? 8'hFF : 8'($urandom);
      b.det_hit = hits[c];
      ev  = c >= 2 && c <= W + 1;
      exp = {c == 1, ev ? d[W + 1 - (ev ? c : 2)] : 1'b0, ev, c >= 1 && c <= W + D + 1,
             c == W + D + 2, c == 0 ? prev : sat_hits(hits, c, 15)};
      if (obs !== exp) begin
        $display("FAIL run d=%h c=%0d obs=%b exp=%b", d, c, obs, exp);
        failures++;
      end
      checks++;
      tick();
    end
    prev = sat_hits(hits, RUN, 15);
    b.start   = 0;
    b.det_hit = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      b.start   = 0;
      b.det_hit = 1'($urandom);
      if (obs !== {5'b0, prev}) begin
        $display("FAIL idle i=%0d obs=%b exp=%b", i, obs, {5'b0, prev});
        failures++;
      end
      checks++;
      tick();
    end
    b.det_hit = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    b.start = 1;
    b.data_in = 8'hAA;
    b.det_hit = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs !== 9'b0) begin
        $display("FAIL reset i=%0d obs=%b exp=0", i, obs);
        failures++;
      end
      checks++;
    end
    rst = 0;
    b.start = 0;
    b.det_hit = 0;
    tick();
    if (obs !== 9'b0) begin
      $display("FAIL reset_release obs=%b exp=0", obs);
      failures++;
    end
    checks++;
    prev = '0;
  endtask
  task automatic test_stream();
    run(8'hB4, 16'h0, 0);
    idle(1);
  endtask
  task automatic test_count_window();
    run(8'hB4, 16'h0A11, 0);
    idle(4);
    run(8'h5C, 16'h0, 0);
  endtask
  task automatic test_busy_rejection();
    run(8'h00, 16'h0, 1);
    run(8'h81, 16'h0, 0);
  endtask
  task automatic test_saturation();
    logic [2:0] e2;
    b2.data_in = 8'($urandom);
    for (int c = 0; c < RUN + 4; c++) begin
      b2.start   = c == 0;
      b2.det_hit = 1;
      e2 = {c == W + D + 2, c == 0 ? 2'b00 : 2'(sat_hits(16'hFFFF, c, 3))};
      if ({b2.done, b2.hit_count} !== e2) begin
        $display("FAIL saturation c=%0d obs=%b exp=%b", c, {b2.done, b2.hit_count}, e2);
        failures++;
      end
      checks++;
      tick();
    end
    b2.start   = 0;
    b2.det_hit = 0;
  endtask
  task automatic test_abort();
    logic [7:0] d = 8'($urandom);
    b.data_in = d;
    for (int c = 0; c < 6; c++) begin
      b.start = c == 0;
      rst = c == 5;
      if (c == 5 && obs !== {3'b001, 2'b10, 4'd0} && obs !== {3'b011, 2'b10, 4'd0}) begin
        $display("FAIL abort_pre obs=%b exp=0x1_10_0000", obs);
        failures++;
      end
      if (c == 5) checks++;
      tick();
    end
    rst = 0;
    b.start = 0;
    if (obs !== 9'b0) begin
      $display("FAIL abort_post obs=%b exp=0", obs);
      failures++;
    end
    checks++;
    prev = '0;
    tick();
    run(8'($urandom), 16'($urandom), 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run(8'($urandom), 16'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end
  endtask
  initial begin
    b.start = 0;
    b.data_in = '0;
    b.det_hit = 0;
    b2.start = 0;
    b2.data_in = '0;
    b2.det_hit = 0;
    test_reset();
    test_stream();
    test_count_window();
    test_busy_rejection();
    test_saturation();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
